// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider / clock-enable generator with toggle and pulse modes.
// Define CLKDIV_PHASE_EN to add a per-channel start offset (phase) loaded on rst/sync.
module clkdiv_multi #(
    parameter int NUM_CH = 4,
    parameter int N_BIT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       mode,
    input  logic [NUM_CH*N_BIT-1:0] div_n,
    input  logic                    sync,
`ifdef CLKDIV_PHASE_EN
    input  logic [NUM_CH*N_BIT-1:0] phase,
`endif
    output logic [NUM_CH-1:0]       clk_div,
    output logic [NUM_CH-1:0]       tick_rise,
    output logic [NUM_CH-1:0]       tick_fall
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [N_BIT-1:0] cnt;
        logic [N_BIT-1:0] n_act;
        logic             div;
        logic             m_act;
        logic             rise_q;
        logic             fall_q;

        logic [N_BIT-1:0] n_in;
        logic             mode_in;
        logic [N_BIT-1:0] start_cnt;

        logic [N_BIT-1:0] cnt_nxt;
        logic [N_BIT-1:0] n_nxt;
        logic             div_nxt;
        logic             m_nxt;
        logic             rise_nxt;
        logic             fall_nxt;

        assign n_in    = div_n[i*N_BIT +: N_BIT];
        assign mode_in = mode[i];

`ifdef CLKDIV_PHASE_EN
        logic [N_BIT-1:0] ph_in;
        assign ph_in     = phase[i*N_BIT +: N_BIT];
        assign start_cnt = (ph_in > n_in) ? n_in : ph_in;
`else
        assign start_cnt = '0;
`endif

        // Terminal count uses >= so a shadow reloaded lower while disabled can never make cnt wrap.
        always_comb begin
            cnt_nxt  = cnt;
            n_nxt    = n_act;
            div_nxt  = div;
            m_nxt    = m_act;
            rise_nxt = 1'b0;
            fall_nxt = 1'b0;
            if (sync) begin
                cnt_nxt = start_cnt;
                div_nxt = 1'b0;
                n_nxt   = n_in;
                m_nxt   = mode_in;
            end else if (!enable[i]) begin
                n_nxt = n_in;
                m_nxt = mode_in;
            end else if (cnt >= n_act) begin
                cnt_nxt = '0;
                n_nxt   = n_in;
                m_nxt   = mode_in;
                div_nxt = mode_in ? 1'b1 : ~div;
            end else begin
                cnt_nxt = cnt + 1'b1;
                if (m_act) begin
                    div_nxt = 1'b0;
                end
            end
            if (!sync) begin
                rise_nxt = div_nxt & ~div;
                fall_nxt = ~div_nxt & div;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt    <= start_cnt;
                n_act  <= n_in;
                div    <= 1'b0;
                m_act  <= mode_in;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                n_act  <= n_nxt;
                div    <= div_nxt;
                m_act  <= m_nxt;
                rise_q <= rise_nxt;
                fall_q <= fall_nxt;
            end
        end

        assign clk_div[i]   = div;
        assign tick_rise[i] = rise_q;
        assign tick_fall[i] = fall_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Testbench for clkdiv_multi: cycle-level reference model feeding a scoreboard queue,
// plus directed edge/level counts over fixed windows.
module tb_clkdiv_multi;
    localparam int NUM_CH = 2;
    localparam int N_BIT  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    sync;
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH-1:0]       mode;
    logic [NUM_CH*N_BIT-1:0] div_n;
`ifdef CLKDIV_PHASE_EN
    logic [NUM_CH*N_BIT-1:0] phase;
`endif
    logic [NUM_CH-1:0]       clk_div;
    logic [NUM_CH-1:0]       tick_rise;
    logic [NUM_CH-1:0]       tick_fall;

    typedef struct packed {
        logic [NUM_CH-1:0] div;
        logic [NUM_CH-1:0] rise;
        logic [NUM_CH-1:0] fall;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt  [NUM_CH];
    int   m_n    [NUM_CH];
    bit   m_div  [NUM_CH];
    bit   m_mode [NUM_CH];
    int   rise_cnt [NUM_CH];
    int   high_cnt [NUM_CH];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    clkdiv_multi #(.NUM_CH(NUM_CH), .N_BIT(N_BIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .div_n     (div_n),
        .sync      (sync),
`ifdef CLKDIV_PHASE_EN
        .phase     (phase),
`endif
        .clk_div   (clk_div),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall)
    );

    function automatic int n_of(int ch);
        return int'(div_n[ch*N_BIT +: N_BIT]);
    endfunction

    function automatic int start_of(int ch);
`ifdef CLKDIV_PHASE_EN
        int p;
        p = int'(phase[ch*N_BIT +: N_BIT]);
        return (p > n_of(ch)) ? n_of(ch) : p;
`else
        return 0;
`endif
    endfunction

    task automatic check(string tag, logic [NUM_CH-1:0] obs, logic [NUM_CH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_int(string tag, int obs, int expv);
        checks++;
        assert (obs == expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model: advance one clock using the inputs currently driven, queue the expected outputs.
    task automatic model_step();
        exp_t e;
        e = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit prev;
            prev = m_div[ch];
            if (rst || sync) begin
                m_cnt[ch]  = start_of(ch);
                m_div[ch]  = 1'b0;
                m_n[ch]    = n_of(ch);
                m_mode[ch] = mode[ch];
                prev       = 1'b0;
            end else if (!enable[ch]) begin
                m_n[ch]    = n_of(ch);
                m_mode[ch] = mode[ch];
            end else if (m_cnt[ch] == m_n[ch]) begin
                m_cnt[ch]  = 0;
                m_div[ch]  = mode[ch] ? 1'b1 : !m_div[ch];
                m_n[ch]    = n_of(ch);
                m_mode[ch] = mode[ch];
            end else begin
                m_cnt[ch]++;
                if (m_mode[ch]) m_div[ch] = 1'b0;
            end
            e.div[ch]  = m_div[ch];
            e.rise[ch] = m_div[ch] && !prev;
            e.fall[ch] = !m_div[ch] && prev;
        end
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = exp_q.pop_front();
        check("clk_div", clk_div, e.div);
        check("tick_rise", tick_rise, e.rise);
        check("tick_fall", tick_fall, e.fall);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rise_cnt[ch] += int'(tick_rise[ch]);
            high_cnt[ch] += int'(clk_div[ch]);
        end
    endtask

    task automatic apply_stimulus(int cycles);
        repeat (cycles) begin
            model_step();
            @(posedge clk);
            @(negedge clk);
            check_output();
        end
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rise_cnt[ch] = 0;
            high_cnt[ch] = 0;
        end
    endtask

    initial begin
        rst    = 1'b1;
        sync   = 1'b0;
        enable = 2'b11;
        mode   = 2'b10;
        div_n  = {16'd4, 16'd3};
`ifdef CLKDIV_PHASE_EN
        phase  = '0;
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_cnt[ch] = 0; m_n[ch] = 0; m_div[ch] = 0; m_mode[ch] = 0;
        end

        $display("[TB] test 1: ch0 toggle N=3, ch1 pulse N=4");
        apply_stimulus(1);
        check("reset_clk_div", clk_div, 2'b00);
        rst = 1'b0;
        clear_counts();
        apply_stimulus(40);
        check_int("t1_ch0_rises", rise_cnt[0], 5);
        check_int("t1_ch0_high", high_cnt[0], 20);
        check_int("t1_ch1_rises", rise_cnt[1], 8);
        check_int("t1_ch1_high", high_cnt[1], 8);

        $display("[TB] test 2: divide change from 9 to 2 mid half-period");
        rst   = 1'b1;
        mode  = 2'b00;
        div_n = {16'd9, 16'd9};
        apply_stimulus(1);
        rst = 1'b0;
        apply_stimulus(5);
        div_n = {16'd9, 16'd2};
        clear_counts();
        apply_stimulus(40);
        check_int("t2_ch0_rises", rise_cnt[0], 6);

        $display("[TB] test 3: freeze ch0 for 10 clocks");
        rst   = 1'b1;
        div_n = {16'd9, 16'd9};
        apply_stimulus(1);
        rst = 1'b0;
        apply_stimulus(3);
        enable = 2'b10;
        clear_counts();
        apply_stimulus(10);
        check_int("t3_frozen_rises", rise_cnt[0], 0);
        check_int("t3_frozen_high", high_cnt[0], 0);
        enable = 2'b11;
        clear_counts();
        apply_stimulus(30);
        check_int("t3_resume_rises", rise_cnt[0], 2);

        $display("[TB] test 4: sync realigns channels");
        rst   = 1'b1;
        div_n = {16'd5, 16'd3};
        apply_stimulus(1);
        rst = 1'b0;
        apply_stimulus(7);
        sync  = 1'b1;
        div_n = {16'd3, 16'd3};
        apply_stimulus(1);
        check("t4_sync_clk_div", clk_div, 2'b00);
        sync = 1'b0;
        apply_stimulus(16);
`ifdef CLKDIV_PHASE_EN
        phase = {16'd2, 16'd0};
        sync  = 1'b1;
        apply_stimulus(1);
        sync = 1'b0;
        apply_stimulus(12);
        phase = {16'd7, 16'd0};
        sync  = 1'b1;
        apply_stimulus(1);
        sync = 1'b0;
        apply_stimulus(12);
        phase = '0;
`endif

        $display("[TB] test 5: N=0 in both modes");
        rst   = 1'b1;
        mode  = 2'b10;
        div_n = '0;
        apply_stimulus(1);
        rst = 1'b0;
        clear_counts();
        apply_stimulus(10);
        check_int("t5_toggle_rises", rise_cnt[0], 5);
        check_int("t5_pulse_rises", rise_cnt[1], 1);
        check_int("t5_pulse_high", high_cnt[1], 10);

        $display("[TB] test 6: reset mid-operation");
        rst   = 1'b1;
        mode  = 2'b00;
        div_n = {16'd3, 16'd3};
        apply_stimulus(1);
        rst = 1'b0;
        apply_stimulus(6);
        rst   = 1'b1;
        div_n = {16'd5, 16'd5};
        apply_stimulus(1);
        check("t6_rst_clk_div", clk_div, 2'b00);
        check("t6_rst_ticks", tick_rise | tick_fall, 2'b00);
        rst   = 1'b0;
        div_n = {16'd2, 16'd2};
        clear_counts();
        apply_stimulus(6);
        check_int("t6_first_toggle_rises", rise_cnt[0], 1);
        check_int("t6_first_toggle_high", high_cnt[0], 1);
        apply_stimulus(12);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
